// File: rtl/voice_mixer.sv
// voice_mixer: gathers one sample from each of three voices per frame.
// Late voices are dropped after a timeout and reuse their last held sample.
// The voices are summed one per cycle into an 18-bit accumulator, which
// cannot overflow with three 16-bit inputs. The sum is then attenuated,
// clamped to 16 bits and emitted with a one-cycle valid pulse.
module voice_mixer #(
  parameter int TIMEOUT = 8,
  parameter int TW      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in_0,
  input  logic [15:0] sample_in_1,
  input  logic [15:0] sample_in_2,
  input  logic        sample_valid_0,
  input  logic        sample_valid_1,
  input  logic        sample_valid_2,
  input  logic [2:0]  voice_mute,
  input  logic [1:0]  master_shift,
  output logic [15:0] mixed_sample,
  output logic        mixed_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_seen
);

  typedef enum logic [2:0] {IDLE, COLLECT, SUM0, SUM1, SUM2, OUT} state_t;

  state_t             state_reg, state_next;
  logic [TW-1:0]      wait_cnt_reg;
  logic [2:0]         valid_vec, arrived_vec, pending_vec, overrun_hit;
  logic [15:0]        sample_vec [3];
  logic [15:0]        work_vec [3];
  logic               snapshot, timeout_hit;
  logic [2:0]         mute_reg;
  logic [1:0]         shift_reg;
  logic signed [17:0] acc_reg, addend, shifted;
  logic [15:0]        clamped;
  logic [15:0]        mixed_sample_reg;
  logic               mixed_valid_reg, overrun_reg, timeout_seen_reg;

  assign valid_vec     = {sample_valid_2, sample_valid_1, sample_valid_0};
  assign sample_vec[0] = sample_in_0;
  assign sample_vec[1] = sample_in_1;
  assign sample_vec[2] = sample_in_2;
  assign pending_vec   = arrived_vec | valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_voice
      logic [15:0] hold_reg, work_reg;
      logic        arrived_reg;

      // Per-voice capture into hold; copy to work when a frame is snapshotted
      always_ff @(posedge clk) begin
        if (reset) begin
          hold_reg    <= '0;
          work_reg    <= '0;
          arrived_reg <= 1'b0;
        end else begin
          if (valid_vec[gi])
            hold_reg <= sample_vec[gi];
          if (snapshot) begin
            // A same-cycle valid belongs to the frame being snapshotted
            work_reg    <= valid_vec[gi] ? sample_vec[gi] : hold_reg;
            arrived_reg <= 1'b0;
          end else if (valid_vec[gi]) begin
            arrived_reg <= 1'b1;
          end
        end
      end

      assign arrived_vec[gi] = arrived_reg;
      assign work_vec[gi]    = work_reg;
      assign overrun_hit[gi] = valid_vec[gi] & arrived_reg & ~snapshot;
    end
  endgenerate

  // Next-state logic, snapshot strobe and timeout detection
  always_comb begin
    state_next  = state_reg;
    snapshot    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_vec == 3'b111) begin
          state_next = SUM0;
          snapshot   = 1'b1;
        end else if (|pending_vec) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (pending_vec == 3'b111) begin
          state_next = SUM0;
          snapshot   = 1'b1;
        end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
          state_next  = SUM0;
          snapshot    = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      SUM0:    state_next = SUM1;
      SUM1:    state_next = SUM2;
      SUM2:    state_next = OUT;
      OUT:     state_next = (|arrived_vec) ? COLLECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Select the sign-extended voice for this summing cycle, zero when muted
  always_comb begin
    addend = '0;
    case (state_reg)
      SUM0: if (!mute_reg[0]) addend = {{2{work_vec[0][15]}}, work_vec[0]};
      SUM1: if (!mute_reg[1]) addend = {{2{work_vec[1][15]}}, work_vec[1]};
      SUM2: if (!mute_reg[2]) addend = {{2{work_vec[2][15]}}, work_vec[2]};
      default: addend = '0;
    endcase
  end

  // Attenuate and clamp the finished sum to the signed 16-bit range
  always_comb begin
    shifted = acc_reg >>> shift_reg;
    if (shifted > 18'sd32767)
      clamped = 16'h7FFF;
    else if (shifted < -18'sd32768)
      clamped = 16'h8000;
    else
      clamped = shifted[15:0];
  end

  // State, accumulator, latched controls and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      wait_cnt_reg     <= '0;
      acc_reg          <= '0;
      mute_reg         <= '0;
      shift_reg        <= '0;
      mixed_sample_reg <= '0;
      mixed_valid_reg  <= 1'b0;
      overrun_reg      <= 1'b0;
      timeout_seen_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= (state_reg == COLLECT) ? wait_cnt_reg + 1'b1 : '0;
      mixed_valid_reg <= (state_reg == OUT);
      if (snapshot) begin
        acc_reg   <= '0;
        mute_reg  <= voice_mute;
        shift_reg <= master_shift;
      end else if (state_reg == SUM0 || state_reg == SUM1 || state_reg == SUM2) begin
        acc_reg <= acc_reg + addend;
      end
      if (state_reg == OUT)
        mixed_sample_reg <= clamped;
      if (timeout_hit)
        timeout_seen_reg <= 1'b1;
      if (|overrun_hit)
        overrun_reg <= 1'b1;
    end
  end

  assign mixed_sample = mixed_sample_reg;
  assign mixed_valid  = mixed_valid_reg;
  assign overrun      = overrun_reg;
  assign timeout_seen = timeout_seen_reg;
  assign busy         = (state_reg == SUM0) || (state_reg == SUM1) ||
                        (state_reg == SUM2) || (state_reg == OUT);

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Sits between the three note_player voices and codec_conditioner.
- Collects one sample per voice per frame, tolerating skewed valid pulses, and drops late voices after a timeout.
- Sums the voices sequentially with per-voice mute and master attenuation, saturates the result, and emits one 16-bit signed sample with a one-cycle valid pulse.
- Replaces the combinational shift-and-add with registered, overflow-safe mixing.

Parameters:
- TIMEOUT, 8: cycles to wait in COLLECT after the first voice arrives before mixing without the missing voices.
- TW, 4: width of the wait counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sample_in_0  input  16  voice 0 sample, signed two's complement
- sample_in_1  input  16  voice 1 sample, signed
- sample_in_2  input  16  voice 2 sample, signed
- sample_valid_0  input  1  one-cycle pulse: sample_in_0 is valid
- sample_valid_1  input  1  one-cycle pulse: sample_in_1 is valid
- sample_valid_2  input  1  one-cycle pulse: sample_in_2 is valid
- voice_mute  input  3  bit i=1 means voice i contributes 0
- master_shift  input  2  arithmetic right-shift of the sum (0..3)
- mixed_sample  output  16  saturated mixed sample, signed, held between updates
- mixed_valid  output  1  one-cycle pulse when mixed_sample updates
- busy  output  1  high in SUM0, SUM1, SUM2 and OUT
- overrun  output  1  sticky: a voice re-arrived before its previous sample was consumed
- timeout_seen  output  1  sticky: at least one frame was mixed on timeout

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; hold/work registers, arrived[2:0], wait_cnt and accumulator cleared.
  - mixed_sample=0, mixed_valid=0, busy=0, overrun=0, timeout_seen=0.
  - Reset asserted mid-frame aborts it: no mixed_valid pulse follows.
- Capture, in every state:
  - sample_valid_i high latches sample_in_i into hold_i and sets arrived[i].
  - If arrived[i] is already 1 and is not being cleared that cycle: hold_i is overwritten and overrun is set.
- Snapshot, on the edge leaving IDLE/COLLECT for SUM0:
  - hold_0..2, including any same-cycle valids, are copied to work_0..2.
  - voice_mute and master_shift are latched.
  - arrived cleared; acc=0.
  - Valids arriving during SUM/OUT go to hold/arrived for the next frame and do not disturb the current mix.
- A voice that never arrived contributes its last held value (hold-last, avoids clicks); 0 after reset.
- State machine:
  - IDLE:
    - If (arrived|valids)==3'b111 -> SUM0.
    - Else if any bit set -> COLLECT with wait_cnt=0.
    - Else stay.
  - COLLECT, wait_cnt increments each cycle:
    - If (arrived|valids)==3'b111 -> SUM0.
    - Else if wait_cnt==TIMEOUT-1 -> SUM0 and set timeout_seen.
  - SUM0/SUM1/SUM2:
    - acc += muted ? 0 : sign-extended work_i (i=0,1,2), one voice per cycle.
    - acc is 18-bit signed; no overflow is possible.
  - OUT:
    - shifted = acc >>> master_shift.
    - Clamp to [-32768, 32767] and register into mixed_sample.
    - mixed_valid=1 in the following cycle only.
    - Next state -> COLLECT (wait_cnt=0) if arrived!=0, else IDLE.
- Latency: if the completing valid is high in cycle 0, mixed_valid is high in cycle 5 and mixed_sample is valid from cycle 5 on.
- Throughput: one frame per 5 cycles minimum, far below the 48 kHz frame rate.
- mixed_valid never stays high for two consecutive cycles.

Test Plan:
- All valids in one cycle: 1000, 2000, -500; shift 0; no mute -> mixed_sample=2500, single mixed_valid pulse exactly 5 cycles later; busy high for 4 cycles.
- Saturation:
  - 30000 x3, shift 0 -> 32767.
  - -30000 x3 -> -32768.
  - 30000 x3, shift 2 -> 22500.
- Skew: v0 at cycle 0, v1 at cycle 2, v2 at cycle 3 (100, 200, 300) -> 600, mixed_valid at cycle 8; timeout_seen stays 0.
- Timeout (TIMEOUT=8):
  - Prior frame leaves hold_2=50.
  - Then only v0=10 and v1=20 arrive at cycle 0.
  - Expected: SUM0 entered after wait_cnt reaches 7, output 80, timeout_seen=1.
- Mute and snapshot:
  - voice_mute=3'b010 with 1000, 2000, 3000 -> 4000.
  - Toggling voice_mute/master_shift during SUM1 leaves the result at 4000.
  - Valids arriving during SUM1 are mixed in the next frame.
- Overrun and reset:
  - Two sample_valid_0 pulses in COLLECT -> overrun=1 and the second value is used.
  - Reset asserted in SUM1 -> no mixed_valid pulse; all outputs 0 the following cycle.
